device_regs_no_function: RTL and testbench

Small memory-mapped register file: four 8-bit read/write control registers addressed through a 4-bit offset bus, with separate single-cycle write and read strobes. It sits behind a simple host/bus-bridge port as a device's configuration space. The read path is registered, and unmapped offsets are benign.

---
 rtl/device_regs_pkg.sv | 26 ++
 rtl/device_reg_cell.sv | 31 +++
 rtl/device_regs_no_function.sv | 70 +++++++
 tb/tb_device_regs_no_function.sv | 133 +++++++++++++
 4 files changed

// File: rtl/device_regs_pkg.sv
// Shared constants for the device configuration register file:
// bus widths, register offsets and reset/unmapped values.
package device_regs_pkg;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 4;

  localparam logic [ADDR_W-1:0] REG0_OFFSET = 4'h0;
  localparam logic [ADDR_W-1:0] REG1_OFFSET = 4'h1;
  localparam logic [ADDR_W-1:0] REG2_OFFSET = 4'h2;
  localparam logic [ADDR_W-1:0] REG3_OFFSET = 4'h3;

  localparam logic [ADDR_W-1:0] REG_OFFSETS [NUM_REGS] =
    '{REG0_OFFSET, REG1_OFFSET, REG2_OFFSET, REG3_OFFSET};

  localparam logic [ADDR_W-1:0] NUM_REGS_ADDR = ADDR_W'(NUM_REGS);

  localparam logic [DATA_W-1:0] RESET_VAL    = 8'h00;
  localparam logic [DATA_W-1:0] UNMAPPED_VAL = 8'h00;

  function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
    return addr < NUM_REGS_ADDR;
  endfunction

endpackage

// File: rtl/device_reg_cell.sv
// One read/write storage register with synchronous active-high reset
// and a write enable; reset wins over a write in the same cycle.
module device_reg_cell
  import device_regs_pkg::*;
#(
  parameter int unsigned     W       = DATA_W,
  parameter logic [W-1:0]    RST_VAL = RESET_VAL
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (we_i) val_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) val_q <= RST_VAL;
    else       val_q <= val_d;
  end

  assign q_o = val_q;

endmodule

// File: rtl/device_regs_no_function.sv
// Memory-mapped configuration space: NUM_REGS read/write registers
// behind a 4-bit offset bus, with a registered read data path.
module device_regs_no_function
  import device_regs_pkg::*;
(
  input  logic              clk,
  input  logic              resetb,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] read_data
);

  // Strobe semantics: write_en and read_en are level-sampled on every
  // rising edge with no handshake; each strobed edge is one access, and
  // a read on the same edge as a write to that offset sees the old value.

  logic                addr_hit;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   reg_q [NUM_REGS];
  logic [DATA_W-1:0]   rd_mux;
  logic [DATA_W-1:0]   read_data_q;
  logic [DATA_W-1:0]   read_data_d;

  assign addr_hit = addr_mapped(address);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = write_en & addr_hit & (address == REG_OFFSETS[i]);
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    device_reg_cell #(
      .W       (DATA_W),
      .RST_VAL (RESET_VAL)
    ) u_cell (
      .clk_i (clk),
      .rst_i (resetb),
      .we_i  (wr_sel[g]),
      .d_i   (data_in),
      .q_o   (reg_q[g])
    );
  end

  // Unmapped offsets read back as a fixed benign value.
  always_comb begin
    rd_mux = UNMAPPED_VAL;
    if (addr_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (address == REG_OFFSETS[i]) rd_mux = reg_q[i];
      end
    end
  end

  always_comb begin
    read_data_d = read_data_q;
    if (read_en) read_data_d = rd_mux;
  end

  always_ff @(posedge clk) begin
    if (resetb) read_data_q <= UNMAPPED_VAL;
    else        read_data_q <= read_data_d;
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_device_regs_no_function.sv
// Directed and random stimulus for the configuration register file,
// checked through an expected-value queue against a small register model.
module tb_device_regs_no_function;

  logic       clk;
  logic       resetb;
  logic [3:0] address;
  logic       write_en;
  logic       read_en;
  logic [7:0] data_in;
  logic [7:0] read_data;

  logic [7:0] exp_q[$];
  logic [7:0] model [4];
  logic [7:0] last_rd;
  int         n_cmp;
  int         n_mis;

  device_regs_no_function dut (
    .clk       (clk),
    .resetb    (resetb),
    .address   (address),
    .write_en  (write_en),
    .read_en   (read_en),
    .data_in   (data_in),
    .read_data (read_data)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // driver: one clock of stimulus, then compare one step after the edge
  task automatic step(input logic rst, input logic we, input logic re,
                      input logic [3:0] a, input logic [7:0] d, input string tag);
    logic [7:0] exp;
    resetb   = rst;
    write_en = we;
    read_en  = re;
    address  = a;
    data_in  = d;
    if (rst) begin
      exp_q.push_back(8'h00);
      for (int i = 0; i < 4; i++) model[i] = 8'h00;
    end else begin
      if (re) exp_q.push_back((a < 4'd4) ? model[a[1:0]] : 8'h00);
      if (we && (a < 4'd4)) model[a[1:0]] = d;
    end
    @(posedge clk);
    #1;
    if (rst || re) begin
      if (exp_q.size() == 0) begin
        check({tag, "_qempty"}, read_data, 8'hxx);
      end else begin
        exp = exp_q.pop_front();
        last_rd = exp;
        check(tag, read_data, exp);
      end
    end else begin
      check({tag, "_hold"}, read_data, last_rd);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_mis    = 0;
    last_rd  = 8'h00;
    resetb   = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    address  = 4'h0;
    data_in  = 8'h00;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;

    // reset held 10 cycles, strobes active underneath it
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 1'b1, 4'(i % 4), 8'($urandom_range(1, 255)), "reset");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'(i), 8'h00, "rd_after_rst");

    // write/read each register
    step(1'b0, 1'b1, 1'b0, 4'h0, 8'hA5, "wr0");
    step(1'b0, 1'b1, 1'b0, 4'h1, 8'hA6, "wr1");
    step(1'b0, 1'b1, 1'b0, 4'h2, 8'hA7, "wr2");
    step(1'b0, 1'b1, 1'b0, 4'h3, 8'hA8, "wr3");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'(i), 8'h00, "rd_each");

    // unmapped offset
    step(1'b0, 1'b1, 1'b0, 4'hF, 8'h5A, "wr_unmapped");
    step(1'b0, 1'b0, 1'b1, 4'hF, 8'h00, "rd_unmapped");
    for (int a = 4; a < 16; a++) step(1'b0, 1'b1, 1'b1, 4'(a), 8'hC3, "rw_unmapped");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'(i), 8'h00, "rd_after_unm");

    // read-during-write returns the old value, then the new one
    step(1'b0, 1'b1, 1'b1, 4'h1, 8'h3C, "rdw_old");
    step(1'b0, 1'b0, 1'b1, 4'h1, 8'h00, "rdw_new");

    // simultaneous strobes on different offsets
    step(1'b0, 1'b1, 1'b1, 4'h2, 8'h11, "rw_diff_a");
    step(1'b0, 1'b1, 1'b1, 4'h0, 8'h22, "rw_diff_b");
    step(1'b0, 1'b0, 1'b1, 4'h2, 8'h00, "rw_diff_c");

    // hold while idle with address toggling, and across a write
    step(1'b0, 1'b0, 1'b1, 4'h3, 8'h00, "rd3");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 8'h00, "idle");
    step(1'b0, 1'b1, 1'b0, 4'h3, 8'h77, "wr3_noread");
    step(1'b0, 1'b0, 1'b1, 4'h3, 8'h00, "rd3_new");

    // reset mid-traffic discards the pending write
    step(1'b0, 1'b0, 1'b1, 4'h1, 8'h00, "pre_rst_rd");
    step(1'b1, 1'b1, 1'b0, 4'h0, 8'hFF, "rst_mid");
    step(1'b0, 1'b0, 1'b1, 4'h0, 8'h00, "rd0_after_rst");
    step(1'b0, 1'b0, 1'b1, 4'h1, 8'h00, "rd1_after_rst");

    // random back-to-back traffic
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 5) == 0 ? $urandom_range(4, 15) : $urandom_range(0, 3)),
           8'($urandom_range(0, 255)), "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
